// File: rtl/instr_loader_if.sv
// Byte-stream input and one-word instruction-memory write port of the program loader.
// The master modport is the loader side; the slave modport is the stream source and memory side.
interface instr_loader_if #(
    parameter int N = 32
);
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Assembles big-endian words from a byte stream and writes them to consecutive instruction-memory words.
// 4 byte cycles plus 1 write cycle per word; byte_ready is decoded from state only, and bubbles just stretch RECV.
module instr_loader #(
    parameter int N     = 32,
    parameter int Depth = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   len,
    instr_loader_if.master bus,
    output logic           cpu_hold,
    output logic           busy,
    output logic           done,
    output logic           err
);
    localparam int IW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, last_idx;
    logic [1:0]    bcnt;
    logic [23:0]   shreg;
    logic [N-1:0]  addr_q, wdata_q;
    logic          err_q;
    logic          take_start, accept;
    logic          len_zero, len_over, last_word;

    assign len_zero  = (len == '0);
    assign len_over  = (len > N'(Depth));
    assign last_word = (idx == last_idx);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        take_start     = 1'b0;
        accept         = 1'b0;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        cpu_hold       = 1'b1;
        case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    done     = 1'b1;
                    cpu_hold = 1'b0;
                end
                if (start) begin
                    take_start = 1'b1;
                    state_nxt  = (len_zero || len_over) ? DONE : RECV;
                end
            end
            RECV: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    accept = 1'b1;
                    if (bcnt == 2'd3) state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
                state_nxt  = last_word ? DONE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write port is loaded on the 4th byte so it is stable in WRITE and holds afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            last_idx <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (take_start) begin
                idx      <= '0;
                bcnt     <= '0;
                err_q    <= len_over;
                last_idx <= IW'(len - N'(1));
            end
            if (accept) begin
                shreg <= {shreg[15:0], bus.byte_in};
                bcnt  <= bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    addr_q  <= N'(idx);
                    wdata_q <= {shreg, bus.byte_in};
                end
            end
            if (state == WRITE && !last_word) idx <= idx + IW'(1);
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign err           = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: reset, two-word loads with and without bubbles, len edge cases,
// mid-load reset and a full-depth load, each against hand-computed addresses, data and cycle timing.
module tb_instr_loader;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] len   = '0;
    logic        cpu_hold, busy, done, err;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [31:0] txw[$];
    int          acc4[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    instr_loader_if #(.N(32)) bif ();

    instr_loader #(.N(32), .Depth(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bus      (bif),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe with the cycle in which it was seen.
    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            wa.push_back(bif.mem_addr);
            wd.push_back(bif.mem_wdata);
            wc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        acc4.delete();
    endtask

    task automatic do_start(input logic [31:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        int n;
        bif.byte_in    = b;
        bif.byte_valid = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = bif.byte_ready;
            @(posedge clk); #1;
            n++;
        end
        last_acc = cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_accept timeout byte=%h", b);
        end
    endtask

    task automatic send_words(input bit bubble);
        logic [31:0] w;
        for (int i = 0; i < txw.size(); i++) begin
            w = txw[i];
            for (int k = 0; k < 4; k++) begin
                if (bubble && (i != 0 || k != 0)) begin
                    bif.byte_valid = 1'b0;
                    @(posedge clk); #1;
                end
                send_byte(w[31-8*k -: 8]);
                if (k == 3) acc4.push_back(last_acc);
            end
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bif.byte_valid = 1'b1;
        bif.byte_in    = 8'hAA;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bif.byte_ready, bif.mem_we, cpu_hold, busy, done, err} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags got rdy,we,hold,busy,done,err=%b exp=001000",
                     {bif.byte_ready, bif.mem_we, cpu_hold, busy, done, err});
        end
        checks++;
        if (bif.mem_addr !== 32'h0 || bif.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h exp=0/0", bif.mem_addr, bif.mem_wdata);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 0 || bif.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_valid got writes=%0d rdy=%b exp=0/0", wa.size(), bif.byte_ready);
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic test_load2(input bit bubble);
        clear_log();
        txw = '{32'h00011020, 32'h04011020};
        do_start(2);
        @(negedge clk);
        checks++;
        if (bif.byte_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_to_recv got rdy=%b busy=%b exp=1/1", bif.byte_ready, busy);
        end
        @(posedge clk); #1;
        send_words(bubble);
        @(negedge clk);
        checks++;
        if ({bif.mem_we, bif.byte_ready, done, cpu_hold} !== 4'b1001) begin
            errors++;
            $display("FAIL last_write_cycle got we,rdy,done,hold=%b exp=1001",
                     {bif.mem_we, bif.byte_ready, done, cpu_hold});
        end
        @(negedge clk);
        checks++;
        if ({done, cpu_hold, busy, bif.mem_we} !== 4'b1000) begin
            errors++;
            $display("FAIL done_after_write got done,hold,busy,we=%b exp=1000",
                     {done, cpu_hold, busy, bif.mem_we});
        end
        checks++;
        if (bif.mem_addr !== 32'd1 || bif.mem_wdata !== 32'h04011020) begin
            errors++;
            $display("FAIL bus_hold got addr=%h data=%h exp=1/04011020", bif.mem_addr, bif.mem_wdata);
        end
        #1;
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL load2_count bubble=%0d got=%0d exp=2", bubble, wa.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (wa.size() > i && acc4.size() > i) begin
                checks++;
                if (wa[i] !== i || wd[i] !== txw[i] || wc[i] != acc4[i]) begin
                    errors++;
                    $display("FAIL load2_write%0d bubble=%0d got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                             i, bubble, wa[i], wd[i], wc[i], i, txw[i], acc4[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_edges();
        clear_log();
        do_start(0);
        @(negedge clk);
        checks++;
        if ({done, err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL len0 got done,err,busy=%b exp=100", {done, err, busy});
        end
        @(posedge clk); #1;
        do_start(33);
        @(negedge clk);
        checks++;
        if ({done, err, busy} !== 3'b110) begin
            errors++;
            $display("FAIL len33 got done,err,busy=%b exp=110", {done, err, busy});
        end
        @(posedge clk); #1;
        do_start(1);
        @(negedge clk);
        checks++;
        if ({err, done, busy, bif.byte_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL len1_start got err,done,busy,rdy=%b exp=0011", {err, done, busy, bif.byte_ready});
        end
        @(posedge clk); #1;
        start = 1'b1;
        len   = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy got busy=%b done=%b exp=1/0", busy, done);
        end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL len_edge_no_writes got=%0d exp=0", wa.size());
        end
        @(posedge clk); #1;
        txw = '{32'hDEADBEEF};
        send_words(1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL len1_done got done=%b err=%b exp=1/0", done, err);
        end
        #1;
        checks++;
        if (wa.size() != 1 || wa[0] !== 32'd0 || wd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL len1_write got n=%0d addr=%h data=%h exp 1/0/deadbeef",
                     wa.size(), (wa.size() > 0) ? wa[0] : 32'hx, (wd.size() > 0) ? wd[0] : 32'hx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        clear_log();
        do_start(3);
        txw = '{32'h11223344};
        send_words(1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bif.byte_in    = 8'hCC;
        bif.byte_valid = 1'b1;
        reset          = 1'b1;
        @(posedge clk); #1;
        reset          = 1'b0;
        bif.byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bif.byte_ready, bif.mem_we, cpu_hold, busy, done, err} !== 6'b001000) begin
            errors++;
            $display("FAIL midreset_flags got rdy,we,hold,busy,done,err=%b exp=001000",
                     {bif.byte_ready, bif.mem_we, cpu_hold, busy, done, err});
        end
        checks++;
        if (bif.mem_addr !== 32'h0 || bif.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_bus got addr=%h data=%h exp=0/0", bif.mem_addr, bif.mem_wdata);
        end
        clear_log();
        @(posedge clk); #1;
        do_start(1);
        txw = '{32'hCAFEF00D};
        send_words(1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (wa.size() != 1 || wa[0] !== 32'd0 || wd[0] !== 32'hCAFEF00D || done !== 1'b1) begin
            errors++;
            $display("FAIL postreset_load got n=%0d addr=%h data=%h done=%b exp 1/0/cafef00d/1",
                     wa.size(), (wa.size() > 0) ? wa[0] : 32'hx, (wd.size() > 0) ? wd[0] : 32'hx, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_depth();
        clear_log();
        txw.delete();
        for (int i = 0; i < 32; i++) txw.push_back(32'(i));
        do_start(32);
        send_words(1'b0);
        @(negedge clk);
        checks++;
        if (bif.mem_we !== 1'b1 || bif.mem_addr !== 32'd31 || done !== 1'b0) begin
            errors++;
            $display("FAIL full_last_write got we=%b addr=%h done=%b exp 1/31/0", bif.mem_we, bif.mem_addr, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL full_done got done=%b hold=%b exp=1/0", done, cpu_hold);
        end
        #1;
        checks++;
        if (wa.size() != 32) begin
            errors++;
            $display("FAIL full_count got=%0d exp=32", wa.size());
        end
        for (int i = 0; i < 32; i++) begin
            if (wa.size() > i && acc4.size() > i) begin
                checks++;
                if (wa[i] !== i || wd[i] !== i || wc[i] != acc4[i]) begin
                    errors++;
                    $display("FAIL full_write%0d got addr=%h data=%h cyc=%0d exp addr=data=%h cyc=%0d",
                             i, wa[i], wd[i], wc[i], i, acc4[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bif.byte_in    = 8'h00;
        bif.byte_valid = 1'b0;
        test_reset();
        test_load2(1'b0);
        test_load2(1'b1);
        test_len_edges();
        test_reset_mid();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
